// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - state, opcode and datapath select encodings for the multicycle control FSM
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        JAL      = 4'd9,
        BEQ      = 4'd10
    } statetype_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REG   = 2'b10;

    localparam logic [1:0] SRCB_WDATA = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Unsupported opcodes map to FETCH so DECODE can abandon the instruction.
    function automatic statetype_t decode_target(input logic [6:0] op);
        statetype_t tgt;
        case (op)
            OP_LW, OP_SW: tgt = MEMADR;
            OP_R:         tgt = EXECUTER;
            OP_I:         tgt = EXECUTEI;
            OP_JAL:       tgt = JAL;
            OP_BEQ:       tgt = BEQ;
            default:      tgt = FETCH;
        endcase
        return tgt;
    endfunction

    function automatic logic op_supported(input logic [6:0] op);
        return decode_target(op) != FETCH;
    endfunction

endpackage

// File: rtl/mc_main_fsm.sv
// rtl/mc_main_fsm.sv - multicycle RV32I main control FSM driving datapath selects and enables
module mc_main_fsm
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       zero,
    output logic       pcwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       memwrite,
    output logic       adrsrc,
    output logic [1:0] resultsrc,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic       illegal_op
);

    statetype_t state_q;
    statetype_t state_d;
    logic       pcupdate;
    logic       branch;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:    state_d = DECODE;
            DECODE:   state_d = decode_target(op);
            MEMADR:   state_d = (op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:  state_d = MEMWB;
            EXECUTER: state_d = ALUWB;
            EXECUTEI: state_d = ALUWB;
            JAL:      state_d = ALUWB;
            MEMWB, MEMWRITE, ALUWB, BEQ: state_d = FETCH;
            default:  state_d = FETCH;
        endcase
    end

    always_comb begin
        irwrite    = 1'b0;
        regwrite   = 1'b0;
        memwrite   = 1'b0;
        adrsrc     = 1'b0;
        resultsrc  = RES_ALUOUT;
        alusrca    = SRCA_PC;
        alusrcb    = SRCB_WDATA;
        aluop      = ALUOP_ADD;
        illegal_op = 1'b0;
        pcupdate   = 1'b0;
        branch     = 1'b0;
        case (state_q)
            FETCH: begin
                irwrite   = 1'b1;
                alusrcb   = SRCB_FOUR;
                resultsrc = RES_ALURESULT;
                pcupdate  = 1'b1;
            end
            DECODE: begin
                // Branch target is precomputed here from OldPC + imm.
                alusrca    = SRCA_OLDPC;
                alusrcb    = SRCB_IMM;
                illegal_op = !op_supported(op);
            end
            MEMADR: begin
                alusrca = SRCA_REG;
                alusrcb = SRCB_IMM;
            end
            MEMREAD: begin
                adrsrc = 1'b1;
            end
            MEMWB: begin
                resultsrc = RES_DATA;
                regwrite  = 1'b1;
            end
            MEMWRITE: begin
                adrsrc   = 1'b1;
                memwrite = 1'b1;
            end
            EXECUTER: begin
                alusrca = SRCA_REG;
                aluop   = ALUOP_FUNCT;
            end
            EXECUTEI: begin
                alusrca = SRCA_REG;
                alusrcb = SRCB_IMM;
                aluop   = ALUOP_FUNCT;
            end
            ALUWB: begin
                regwrite = 1'b1;
            end
            JAL: begin
                alusrca  = SRCA_OLDPC;
                alusrcb  = SRCB_FOUR;
                pcupdate = 1'b1;
            end
            BEQ: begin
                alusrca = SRCA_REG;
                aluop   = ALUOP_SUB;
                branch  = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign pcwrite = pcupdate | (branch & zero);

endmodule
